// File: rtl/bitmap_encoder_64x6_pkg.sv
// Shared widths and state encoding for the 64-to-6 sequential bitmap encoder.
package bitmap_encoder_64x6_pkg;
  localparam int VEC_W      = 64;
  localparam int IDX_W      = 6;
  localparam int HALF_W     = 32;
  localparam int HALF_IDX_W = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;
endpackage

// File: rtl/bitmap_encoder_64x6_if.sv
// Bitmap input / index output handshake bundle for bitmap_encoder_64x6.
interface bitmap_encoder_64x6_if;
  import bitmap_encoder_64x6_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [VEC_W-1:0]     in_vec;
  logic                 out_valid;
  logic                 out_ready;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_last;
  logic                 zero_pulse;
  logic                 busy;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, zero_pulse, busy
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, zero_pulse, busy
  );
endinterface

// File: rtl/bitmap_encoder_64x6_priority_encoder_32x5.sv
// Combinational 32-to-5 priority encoder; lowest set bit wins unless MSB_FIRST.
module priority_encoder_32x5
  import bitmap_encoder_64x6_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  en,
  input  logic [HALF_W-1:0]     a,
  output logic [HALF_IDX_W-1:0] y,
  output logic                  any
);
  always_comb begin
    y   = '0;
    any = en & (|a);
    if (en) begin
      // Last match in scan order wins, so scan towards the winning end.
      if (MSB_FIRST) begin
        for (int i = 0; i < HALF_W; i++)
          if (a[i]) y = HALF_IDX_W'(i);
      end else begin
        for (int i = HALF_W - 1; i >= 0; i--)
          if (a[i]) y = HALF_IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/bitmap_encoder_64x6.sv
// Sequential 64-to-6 encoder: accepts a bitmap, then emits one set-bit index per beat.
module bitmap_encoder_64x6
  import bitmap_encoder_64x6_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  bitmap_encoder_64x6_if.slave bus
);
  state_t                  state, state_nxt;
  logic [VEC_W-1:0]        pending, pending_nxt, cleared;
  logic                    zero_q, zero_nxt;
  logic                    drain, lo_any, hi_any, sel_hi, last;
  logic [HALF_IDX_W-1:0]   lo_y, hi_y;
  logic [IDX_W-1:0]        idx;

  assign drain = (state == ST_DRAIN);

  priority_encoder_32x5 #(.MSB_FIRST(MSB_FIRST)) u_lo (
    .en  (drain),
    .a   (pending[HALF_W-1:0]),
    .y   (lo_y),
    .any (lo_any)
  );

  priority_encoder_32x5 #(.MSB_FIRST(MSB_FIRST)) u_hi (
    .en  (drain),
    .a   (pending[VEC_W-1:HALF_W]),
    .y   (hi_y),
    .any (hi_any)
  );

  // Gating with hi_any keeps the index at zero while idle (pending empty).
  assign sel_hi  = MSB_FIRST ? hi_any : (hi_any & ~lo_any);
  assign idx     = {sel_hi, (sel_hi ? hi_y : lo_y)};
  assign cleared = pending & ~({{(VEC_W-1){1'b0}}, 1'b1} << idx);
  assign last    = (lo_any | hi_any) & (cleared == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pending <= '0;
      zero_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      zero_q  <= zero_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    zero_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_vec != '0) begin
            pending_nxt = bus.in_vec;
            state_nxt   = ST_DRAIN;
          end else begin
            zero_nxt = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (bus.out_ready) begin
          pending_nxt = cleared;
          if (last) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready   = ~drain;
    bus.out_valid  = drain;
    bus.busy       = drain;
    bus.out_idx    = idx;
    bus.out_last   = last;
    bus.zero_pulse = zero_q;
  end
endmodule

// File: tb/tb_bitmap_encoder_64x6.sv
// Randomised and directed bench for bitmap_encoder_64x6 in both priority orders.
module tb_bitmap_encoder_64x6;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_vec;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  int cycles;
  int q0[$];
  int q1[$];

  bitmap_encoder_64x6_if b0 ();
  bitmap_encoder_64x6_if b1 ();

  assign b0.in_valid  = in_valid;
  assign b0.in_vec    = in_vec;
  assign b0.out_ready = out_ready;
  assign b1.in_valid  = in_valid;
  assign b1.in_vec    = in_vec;
  assign b1.out_ready = out_ready;

  bitmap_encoder_64x6 #(.MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(b0.slave));
  bitmap_encoder_64x6 #(.MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(b1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected index order: ascending for the LSB-first unit, descending for MSB-first.
  task automatic load_model(input logic [63:0] v);
    q0.delete();
    q1.delete();
    for (int i = 0; i < 64; i++)
      if (v[i]) begin
        q0.push_back(i);
        q1.push_front(i);
      end
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_in_ready0"}, b0.in_ready, 1'b1);
    chk({tag, "_in_ready1"}, b1.in_ready, 1'b1);
    chk({tag, "_out_valid0"}, b0.out_valid, 1'b0);
    chk({tag, "_out_valid1"}, b1.out_valid, 1'b0);
    chk({tag, "_busy0"}, b0.busy, 1'b0);
  endtask

  task automatic drain(input string tag, input logic [63:0] vec, input bit stall, input bit noise, input int hold);
    bit rdy;
    int h;
    h = hold;
    in_valid = 1'b1;
    in_vec   = vec;
    load_model(vec);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cycles   = 0;
    for (int g = 0; g < 4000 && q0.size() > 0; g++) begin
      if (noise) begin
        in_valid = 1'($urandom_range(1, 0));
        in_vec   = {$urandom, $urandom};
      end
      chk({tag, "_valid0"}, b0.out_valid, 1'b1);
      chk({tag, "_valid1"}, b1.out_valid, 1'b1);
      chk({tag, "_idx0"}, b0.out_idx, 64'(q0[0]));
      chk({tag, "_idx1"}, b1.out_idx, 64'(q1[0]));
      chk({tag, "_last0"}, b0.out_last, (q0.size() == 1));
      chk({tag, "_last1"}, b1.out_last, (q1.size() == 1));
      chk({tag, "_in_ready_low"}, b0.in_ready, 1'b0);
      chk({tag, "_busy"}, b0.busy, 1'b1);
      if (h > 0) begin
        rdy = 1'b0;
        h--;
      end else begin
        rdy = stall ? 1'($urandom_range(1, 0)) : 1'b1;
      end
      out_ready = rdy;
      @(posedge clk); #1;
      cycles++;
      if (rdy) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_drained"}, 64'(q0.size()), 64'd0);
    idle_checks({tag, "_end"});
  endtask

  initial begin
    logic [63:0] v;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    #1;
    idle_checks("reset");
    chk("reset_idx0", b0.out_idx, 6'd0);
    chk("reset_idx1", b1.out_idx, 6'd0);
    chk("reset_last0", b0.out_last, 1'b0);
    chk("reset_zero0", b0.zero_pulse, 1'b0);
    #11 rst = 1'b0;
    @(posedge clk); #1;

    drain("pair", 64'h8000_0000_0000_0001, 1'b0, 1'b0, 0);
    drain("bit0", 64'h0000_0000_0000_0001, 1'b0, 1'b0, 0);
    drain("bit63", 64'h8000_0000_0000_0000, 1'b0, 1'b0, 0);
    drain("bp", 64'h0000_0001_0000_0004, 1'b0, 1'b0, 3);

    // Zero bitmaps, two back to back.
    in_valid = 1'b1;
    in_vec   = '0;
    @(posedge clk); #1;
    chk("zero_pulse0_a", b0.zero_pulse, 1'b1);
    chk("zero_pulse1_a", b1.zero_pulse, 1'b1);
    idle_checks("zero_a");
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("zero_pulse0_b", b0.zero_pulse, 1'b1);
    idle_checks("zero_b");
    @(posedge clk); #1;
    chk("zero_pulse0_c", b0.zero_pulse, 1'b0);
    chk("zero_pulse1_c", b1.zero_pulse, 1'b0);
    idle_checks("zero_c");

    drain("ones", '1, 1'b0, 1'b1, 0);
    chk("ones_cycles", 64'(cycles), 64'd64);

    for (int t = 0; t < 8; t++) begin
      v = {$urandom, $urandom} & {$urandom, $urandom};
      v[$urandom_range(63, 0)] = 1'b1;
      drain("rand", v, 1'b1, 1'b1, 0);
    end

    // Asynchronous reset in the middle of a drain.
    in_valid = 1'b1;
    in_vec   = 64'h0000_0000_0000_00F0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_first_idx", b0.out_idx, 6'd4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_second_idx", b0.out_idx, 6'd5);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid0", b0.out_valid, 1'b0);
    chk("rst_async_valid1", b1.out_valid, 1'b0);
    chk("rst_async_idx", b0.out_idx, 6'd0);
    #2 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      idle_checks("rst_after");
    end
    out_ready = 1'b0;

    drain("post_rst", 64'h0000_0000_0000_0100, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
